// File: rtl/bht_update_queue_pkg.sv
// Shared types for the BHT update queue: branch-unit outcome, BHT update
// record, control-flow type and the default queue depth.
package bht_update_queue_pkg;

  localparam int unsigned VLEN                = 32;
  localparam int unsigned BHT_UPD_QUEUE_DEPTH = 4;

  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            is_taken;
    logic            is_mispredict;
    cf_t             cf_type;
  } bp_resolve_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

endpackage

// File: rtl/bht_update_queue_fifo.sv
// Non-fall-through FIFO holding {pc, taken}. The caller gates push so that a
// push into a full FIFO only happens together with a pop. Flush clears the
// pointers and count and overrides any same-cycle push or pop.
module bht_update_queue_fifo #(
  parameter int unsigned DATA_WIDTH = 33,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
  logic [AW-1:0]                    r_wptr;
  logic [AW-1:0]                    r_rptr;
  logic [AW:0]                      r_cnt;

  assign data_o  = r_mem[r_rptr];
  assign full_o  = (r_cnt == FULL_CNT);
  assign empty_o = (r_cnt == '0);

  // Storage and occupancy; pointers are log2(DEPTH) bits and wrap on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (pop_i) r_rptr <= r_rptr + PTR_ONE;
      r_cnt <= r_cnt + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

endmodule

// File: rtl/bht_update_queue.sv
// Filters resolved conditional branches (outside debug mode) into a small
// FIFO and issues one BHT update per cycle from its head. The output depends
// only on FIFO state, bht_stall_i and flush_i, never on the incoming outcome.
// Optional statistics counters are built when BHT_UPD_STATS_EN is defined;
// otherwise the stat outputs are tied to zero and hold no flops.
module bht_update_queue
  import bht_update_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = BHT_UPD_QUEUE_DEPTH,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 debug_mode_i,
  input  bp_resolve_t          resolved_branch_i,
  input  logic                 bht_stall_i,
  output bht_update_t          bht_update_o,
  output logic [CNT_WIDTH-1:0] stat_updates_o,
  output logic [CNT_WIDTH-1:0] stat_mispredicts_o,
  output logic [CNT_WIDTH-1:0] stat_drops_o
);

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic            w_full;
  logic            w_empty;
  logic [VLEN:0]   w_head;

  assign w_accept = resolved_branch_i.valid && (resolved_branch_i.cf_type == Branch)
                    && !debug_mode_i && !flush_i;
  assign w_pop    = !w_empty && !bht_stall_i && !flush_i;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push   = w_accept && (!w_full || w_pop);
  assign w_drop   = w_accept && w_full && !w_pop;

  bht_update_queue_fifo #(
    .DATA_WIDTH (VLEN + 1),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  ({resolved_branch_i.pc, resolved_branch_i.is_taken}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Head is shown even while stalled; pc/taken read as zero when empty.
  always_comb begin
    bht_update_o       = '0;
    bht_update_o.valid = w_pop;
    if (!w_empty) begin
      bht_update_o.pc    = w_head[VLEN:1];
      bht_update_o.taken = w_head[0];
    end
  end

`ifdef BHT_UPD_STATS_EN
  logic [CNT_WIDTH-1:0] r_upd_cnt;
  logic [CNT_WIDTH-1:0] r_misp_cnt;
  logic [CNT_WIDTH-1:0] r_drop_cnt;

  // Free-running statistics; wrap naturally and survive flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_upd_cnt  <= '0;
      r_misp_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop)                                     r_upd_cnt  <= r_upd_cnt + 1'b1;
      if (w_push && resolved_branch_i.is_mispredict) r_misp_cnt <= r_misp_cnt + 1'b1;
      if (w_drop)                                    r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign stat_updates_o     = r_upd_cnt;
  assign stat_mispredicts_o = r_misp_cnt;
  assign stat_drops_o       = r_drop_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats     = resolved_branch_i.is_mispredict ^ w_drop;
  assign stat_updates_o     = '0;
  assign stat_mispredicts_o = '0;
  assign stat_drops_o       = '0;
`endif

endmodule

// File: tb/tb_bht_update_queue.sv
// Randomized + directed bench for bht_update_queue against a queue-based
// reference model. Stat expectations follow BHT_UPD_STATS_EN.
module tb_bht_update_queue;
  import bht_update_queue_pkg::*;

  localparam int DEPTH = 4;
`ifdef BHT_UPD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            tk;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        dbg = 1'b0;
  logic        stall = 1'b0;
  bp_resolve_t rb = '0;
  bht_update_t upd;
  logic [31:0] st_upd, st_misp, st_drop;

  int n_chk = 0;
  int n_fail = 0;

  ent_t        q[$];
  logic [31:0] m_upd = 0, m_misp = 0, m_drop = 0;

  always #5 clk = ~clk;

  bht_update_queue #(.DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .flush_i            (flush),
    .debug_mode_i       (dbg),
    .resolved_branch_i  (rb),
    .bht_stall_i        (stall),
    .bht_update_o       (upd),
    .stat_updates_o     (st_upd),
    .stat_mispredicts_o (st_misp),
    .stat_drops_o       (st_drop)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check outputs against the model, advance model.
  task automatic cyc(input logic fl, input logic dm, input logic v, input cf_t cf,
                     input logic [VLEN-1:0] pc, input logic tk, input logic mp,
                     input logic st);
    logic e_v, acc, full;
    @(negedge clk);
    flush = fl; dbg = dm; stall = st;
    rb.valid = v; rb.cf_type = cf; rb.pc = pc; rb.is_taken = tk; rb.is_mispredict = mp;
    #1;
    chk("stat_updates", st_upd, STATS ? m_upd : 32'd0);
    chk("stat_mispredicts", st_misp, STATS ? m_misp : 32'd0);
    chk("stat_drops", st_drop, STATS ? m_drop : 32'd0);
    e_v = !fl && (q.size() > 0) && !st;
    chk("valid", upd.valid, e_v);
    if (q.size() > 0) begin
      chk("head_pc", upd.pc, q[0].pc);
      chk("head_taken", upd.taken, q[0].tk);
    end
    acc  = v && (cf == Branch) && !dm && !fl;
    full = (q.size() == DEPTH);
    if (fl) q.delete();
    else begin
      if (acc) begin
        if (!full || e_v) begin
          q.push_back('{pc: pc, tk: tk});
          if (mp) m_misp++;
        end else m_drop++;
      end
      if (e_v) begin
        void'(q.pop_front());
        m_upd++;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, NoCF, '0, 1'b0, 1'b0, st);
  endtask

  task automatic br(input logic [VLEN-1:0] pc, input logic tk, input logic st);
    cyc(1'b0, 1'b0, 1'b1, Branch, pc, tk, 1'b0, st);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_update", upd, '0);
    chk("rst_stat_upd", st_upd, 32'd0);
    chk("rst_stat_misp", st_misp, 32'd0);
    chk("rst_stat_drop", st_drop, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset, then a single taken branch
    idle(10, 1'b0);
    idle(4, 1'b0);
    br(32'h8000_0010, 1'b1, 1'b0);
    idle(3, 1'b0);

    // Filtering: JumpR, debug-mode branch, mispredicted branch
    cyc(1'b0, 1'b0, 1'b1, JumpR, 32'h100, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, Branch, 32'h104, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, Branch, 32'h108, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);

    // Stalled fill beyond capacity: two drops, then in-order drain
    for (int i = 0; i < 6; i++) br(VLEN'(4 * i), i[0], 1'b1);
    idle(1, 1'b1);
    chk("drops_after_fill", st_drop, STATS ? 32'd2 : 32'd0);
    idle(6, 1'b0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) br(VLEN'(32'h200 + 4 * i), 1'b1, 1'b1);
    br(32'h300, 1'b0, 1'b0);
    idle(6, 1'b0);

    // Flush with a same-cycle push, then a later single push
    for (int i = 0; i < 3; i++) br(VLEN'(32'h400 + 4 * i), 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, Branch, 32'h500, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    br(32'h600, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int   r;
      cf_t  cf;
      r  = int'($urandom_range(0, 7));
      cf = (r < 4) ? Branch : cf_t'(r - 3);
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) < 7, cf, VLEN'($urandom) & ~VLEN'(1),
          1'($urandom), 1'($urandom), $urandom_range(0, 9) < 3);
    end
    idle(8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
